sap_cpu_param: RTL and testbench
================================

// Module: sap_cpu_param
// PURPOSE
//  Parametrised SAP-family CPU core, successor to the fixed 8-bit SAP-1 (LDA/ADD/SUB/OUT/HLT).
//  Generalised data/address width; adds STA, LDI, JMP, JC, JZ, carry/zero flags and run/step gating.
//  Talks to an external synchronous single-port RAM that holds both program and data.
// PARAMETERS
//  DATA_W    9  memory word / accumulator width; must be >= 4+ADDR_W
//  ADDR_W    5  address width; PC and operand width
//  PC_RESET  0  PC value loaded on reset
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst         in   1       synchronous reset, active-low
//  run         in   1       1: free-run; 0: hold at start of next instruction (T1)
//  mem_addr    out  ADDR_W  RAM address (combinational from state/PC/IR)
//  mem_rdata   in   DATA_W  RAM read data; reflects the mem_addr of the previous cycle
//  mem_wdata   out  DATA_W  RAM write data (= A)
//  mem_we      out  1       RAM write strobe, one cycle
//  out_data    out  DATA_W  output register
//  out_valid   out  1       one-cycle pulse when out_data is loaded
//  instr_done  out  1       one-cycle pulse on the last T-state of each instruction
//  halted      out  1       1 after HLT executes, until reset
//  pc_o        out  ADDR_W  program counter
//  acc_o       out  DATA_W  accumulator A
//  flag_c      out  1       carry flag
//  flag_z      out  1       zero flag
// BEHAVIOUR
//  Instruction: opcode = word[ADDR_W+3:ADDR_W], operand = word[ADDR_W-1:0]; upper bits ignored.
//  Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, E OUT, F HLT; others = NOP.
//  Reset (rst=0 at edge): PC=PC_RESET, A=IR=0, C=Z=0, out_data=0, pulses=0, halted=0, state=T1.
//  FSM (one state per cycle):
//   T1 FETCH : mem_addr=PC. If run=0, stay in T1 (no side effects); else ->T2.
//   T2 WAIT  : PC<=PC+1 (mod 2^ADDR_W) ->T3.
//   T3 DECODE: IR<=mem_rdata ->T4.
//   T4 EXEC1 : LDA/ADD/SUB: mem_addr=operand ->T5.
//              STA: mem_addr=operand, mem_we=1, mem_wdata=A ->T1.
//              LDI: A<=zero-extended operand; flags unchanged ->T1.
//              JMP: PC<=operand. JC/JZ: PC<=operand iff C/Z=1 ->T1.
//              OUT: out_data<=A, out_valid=1 next cycle ->T1.  NOP ->T1.
//              HLT: ->HALT.
//   T5 WAIT  : mem_addr=operand held ->T6.
//   T6 EXEC3 : LDA: A<=rdata. ADD: {C,A}<=A+rdata. SUB: A<=A-rdata, C<=1 iff A>=rdata (no borrow).
//              Z<=(new A==0) for LDA/ADD/SUB; LDA leaves C unchanged ->T1.
//   HALT     : absorbing; halted=1; mem_we=0; leaves only via reset.
//  instr_done asserted during T4 for 4-cycle instructions, T6 for 6-cycle; 0 in HALT.
//  Latency: 4 cycles NOP/STA/LDI/JMP/JC/JZ/OUT/HLT, 6 cycles LDA/ADD/SUB (run=1).
//  Arithmetic modulo 2^DATA_W; PC wraps 2^ADDR_W-1 -> 0 without any flag.
//  Self-modifying code: STA to the next fetch address is visible on that fetch.
//  mem_we is never asserted outside T4 of STA, nor during reset.
//  run sampled only in T1; deasserting run mid-instruction completes that instruction.
//  rst=0 in any state overrides all transitions; reset wins over HLT/STA in the same cycle.
// TESTING
//  1 mem0=LDA 9,1=ADD 10,2=SUB 11,3=OUT,4=HLT; m9=16,m10=20,m11=24 -> out_data=12 pulse, halted at cycle 26.
//  2 m0=LDA 8,1=ADD 9,2=JC 5,5=JZ 7,7=HLT; m8=511,m9=1 -> A=0,C=1,Z=1, PC path 0,1,2,5,7, halted.
//  3 m0=LDI 5,1=STA 20,2=HLT -> exactly one mem_we cycle, mem_addr=20, mem_wdata=5; A=5, flags 0.
//  4 m0=JMP 31, m31=NOP, m0 again -> PC goes 31 then wraps to 0; loop repeats, no halt.
//  5 run=0 from reset for 10 cycles -> state T1, PC=0, no pulses; run=1 -> fetch of m0 proceeds normally.
//  6 rst=0 during T5 of ADD -> next cycle A=0, PC=0, C=Z=0, state T1, mem_we=0; program restarts.

Source files
------------

// File: rtl/sap_cpu_param.sv
// Parametrised SAP-family CPU core: multi-cycle fetch/decode/execute over a shared
// synchronous single-port RAM, with carry/zero flags, run gating and halt.
module sap_cpu_param #(
    parameter int          DATA_W   = 9,
    parameter int          ADDR_W   = 5,
    parameter int unsigned PC_RESET = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    output logic              o_instr_done,
    output logic              o_halted,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_acc,
    output logic              o_flag_c,
    output logic              o_flag_z
);

    typedef enum logic [2:0] {S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} state_t;

    localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4,
                           OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8,
                           OP_OUT = 4'hE, OP_HLT = 4'hF;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W+3:0]   r_ir;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_out;
    logic                r_out_valid;
    logic                r_c;
    logic                r_z;

    logic [3:0]          w_op;
    logic [ADDR_W-1:0]   w_opd;
    logic                w_long;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_diff;

    assign w_op   = r_ir[ADDR_W+3:ADDR_W];
    assign w_opd  = r_ir[ADDR_W-1:0];
    assign w_long = (w_op == OP_LDA) || (w_op == OP_ADD) || (w_op == OP_SUB);
    assign w_sum  = {1'b0, r_a} + {1'b0, i_mem_rdata};
    assign w_diff = r_a - i_mem_rdata;

    // Operand address is held through T4..T6 so the RAM's one-cycle read lands in T6.
    always_comb begin
        o_mem_addr = r_pc;
        if (r_state == S_T4 || r_state == S_T5 || r_state == S_T6)
            o_mem_addr = w_opd;
    end

    // Reset must suppress a write even if the core sits in T4 of STA.
    assign o_mem_we     = i_rst && (r_state == S_T4) && (w_op == OP_STA);
    assign o_mem_wdata  = r_a;
    assign o_instr_done = ((r_state == S_T4) && !w_long) || (r_state == S_T6);
    assign o_halted     = (r_state == S_HALT);
    assign o_out_data   = r_out;
    assign o_out_valid  = r_out_valid;
    assign o_pc         = r_pc;
    assign o_acc        = r_a;
    assign o_flag_c     = r_c;
    assign o_flag_z     = r_z;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= S_T1;
            r_pc        <= ADDR_W'(PC_RESET);
            r_ir        <= '0;
            r_a         <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_T1: if (i_run) r_state <= S_T2;
                S_T2: begin
                    r_pc    <= r_pc + 1'b1;
                    r_state <= S_T3;
                end
                S_T3: begin
                    r_ir    <= i_mem_rdata[ADDR_W+3:0];
                    r_state <= S_T4;
                end
                S_T4: begin
                    r_state <= S_T1;
                    case (w_op)
                        OP_LDA, OP_ADD, OP_SUB: r_state <= S_T5;
                        OP_LDI: r_a <= {{(DATA_W-ADDR_W){1'b0}}, w_opd};
                        OP_JMP: r_pc <= w_opd;
                        OP_JC:  if (r_c) r_pc <= w_opd;
                        OP_JZ:  if (r_z) r_pc <= w_opd;
                        OP_OUT: begin
                            r_out       <= r_a;
                            r_out_valid <= 1'b1;
                        end
                        OP_HLT: r_state <= S_HALT;
                        default: ;
                    endcase
                end
                S_T5: r_state <= S_T6;
                S_T6: begin
                    r_state <= S_T1;
                    case (w_op)
                        OP_LDA: begin
                            r_a <= i_mem_rdata;
                            r_z <= (i_mem_rdata == '0);
                        end
                        OP_ADD: begin
                            {r_c, r_a} <= w_sum;
                            r_z        <= (w_sum[DATA_W-1:0] == '0);
                        end
                        OP_SUB: begin
                            r_a <= w_diff;
                            r_c <= (r_a >= i_mem_rdata);
                            r_z <= (w_diff == '0);
                        end
                        default: ;
                    endcase
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_cpu_param.sv
// Bench for sap_cpu_param: instruction-level reference interpreter plus a synchronous
// RAM model; directed programs and random programs with random run gating.
module tb_sap_cpu_param;
    localparam int DW = 9, AW = 5, DEPTH = 32;

    logic          clk = 1'b0, rst = 1'b0, run = 1'b0, load = 1'b0;
    logic [AW-1:0] mem_addr, pc;
    logic [DW-1:0] mem_rdata, mem_wdata, out_data, acc;
    logic          mem_we, out_valid, done, halted, fc, fz;

    sap_cpu_param #(.DATA_W(DW), .ADDR_W(AW), .PC_RESET(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_run(run),
        .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
        .o_out_data(out_data), .o_out_valid(out_valid), .o_instr_done(done), .o_halted(halted),
        .o_pc(pc), .o_acc(acc), .o_flag_c(fc), .o_flag_z(fz)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] img [DEPTH];
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= img[i];
        end else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Reference machine state
    logic [DW-1:0] m_mem [DEPTH];
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_a, m_out;
    logic          m_c, m_z, m_halt;

    int n_tests = 0, n_fail = 0;
    int tot, cyc, ndone, we_cnt, hlt_tot;
    bit pend, pend_out, lat_on;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] enc(input int op, input int opd);
        logic [DW-1:0] w;
        w = '0;
        w[AW+3:AW] = op[3:0];
        w[AW-1:0]  = opd[AW-1:0];
        return w;
    endfunction

    // Execute one whole instruction at the architectural level.
    task automatic model_step(output int lat, output bit is_sta, output logic [AW-1:0] sa,
                              output bit is_out, output bit is_hlt);
        logic [DW-1:0] w, m;
        logic [DW:0]   sum;
        int            op;
        logic [AW-1:0] opd;
        w = m_mem[m_pc];
        op = int'(w[AW+3:AW]);
        opd = w[AW-1:0];
        m = m_mem[opd];
        m_pc = m_pc + 1'b1;
        lat = 4; is_sta = 0; sa = opd; is_out = 0; is_hlt = 0;
        case (op)
            1: begin lat = 6; m_a = m; m_z = (m_a == 0); end
            2: begin lat = 6; sum = m_a + m; m_c = sum[DW]; m_a = sum[DW-1:0]; m_z = (m_a == 0); end
            3: begin lat = 6; m_c = (m_a >= m); m_a = m_a - m; m_z = (m_a == 0); end
            4: begin is_sta = 1; m_mem[opd] = m_a; end
            5: m_a = DW'(opd);
            6: m_pc = opd;
            7: if (m_c) m_pc = opd;
            8: if (m_z) m_pc = opd;
            14: begin is_out = 1; m_out = m_a; end
            15: begin m_halt = 1; is_hlt = 1; end
            default: ;
        endcase
    endtask

    task automatic monitor();
        int lat; bit sta, isout, ishlt; logic [AW-1:0] sa;
        cyc++;
        if (pend) begin
            check("pc", pc, m_pc);
            check("acc", acc, m_a);
            check("flag_c", fc, m_c);
            check("flag_z", fz, m_z);
            check("halted", halted, m_halt);
            check("out_valid", out_valid, pend_out);
            if (pend_out) check("out_data", out_data, m_out);
            pend = 0;
        end else if (out_valid) check("out_valid_stray", out_valid, 0);
        if (mem_we) begin
            we_cnt++;
            if (!done) check("we_stray", mem_we, 0);
        end
        if (done) begin
            if (m_halt) check("done_after_halt", done, 0);
            else begin
                model_step(lat, sta, sa, isout, ishlt);
                if (lat_on) check("latency", cyc, lat);
                check("mem_we", mem_we, sta);
                if (sta) begin
                    check("sta_addr", mem_addr, sa);
                    check("sta_wdata", mem_wdata, m_a);
                end
                if (ishlt) hlt_tot = tot;
                pend = 1; pend_out = isout; cyc = 0; ndone++;
            end
        end
    endtask

    task automatic cycle(input bit mon);
        @(negedge clk);
        tot++;
        if (mon) monitor();
    endtask

    task automatic start(input bit run_v);
        rst = 0; load = 1; run = run_v;
        cycle(0); cycle(0);
        check("rst_pc", pc, 0);
        check("rst_acc", acc, 0);
        check("rst_flags", {fc, fz}, 0);
        check("rst_pulses", {out_valid, mem_we, halted}, 0);
        load = 0; rst = 1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = img[i];
        m_pc = 0; m_a = 0; m_c = 0; m_z = 0; m_halt = 0; m_out = 0;
        pend = 0; cyc = 1; tot = 1; ndone = 0; we_cnt = 0; hlt_tot = 0; lat_on = 1;
    endtask

    task automatic run_prog(input int max, input bit rand_run);
        for (int i = 0; i < max; i++) begin
            cycle(1);
            if (rand_run) run = ($urandom_range(0, 3) != 0);
            if (m_halt && !pend) break;
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < DEPTH; i++) img[i] = '0;
    endtask

    initial begin
        // 1: LDA/ADD/SUB/OUT/HLT
        clear_img();
        img[0] = enc(1, 9); img[1] = enc(2, 10); img[2] = enc(3, 11); img[3] = enc(14, 0); img[4] = enc(15, 0);
        img[9] = 16; img[10] = 20; img[11] = 24;
        start(1);
        run_prog(100, 0);
        check("t1_out", out_data, 12);
        check("t1_halted", halted, 1);
        check("t1_hlt_cycle", hlt_tot, 26);

        // 2: carry/zero and conditional jumps
        clear_img();
        img[0] = enc(1, 8); img[1] = enc(2, 9); img[2] = enc(7, 5); img[5] = enc(8, 7); img[7] = enc(15, 0);
        img[8] = 511; img[9] = 1;
        start(1);
        run_prog(100, 0);
        check("t2_acc", acc, 0);
        check("t2_cz", {fc, fz}, 2'b11);
        check("t2_pc", pc, 8);
        check("t2_halted", halted, 1);

        // 3: LDI + STA, single write strobe
        clear_img();
        img[0] = enc(5, 5); img[1] = enc(4, 20); img[2] = enc(15, 0);
        start(1);
        run_prog(100, 0);
        check("t3_we_cnt", we_cnt, 1);
        check("t3_ram20", ram[20], 5);
        check("t3_acc", acc, 5);
        check("t3_flags", {fc, fz}, 0);

        // 4: jump to top address, PC wraps to 0
        clear_img();
        img[0] = enc(6, 31);
        start(1);
        run_prog(80, 0);
        check("t4_not_halted", halted, 0);
        check("t4_progress", ndone > 8, 1);

        // 5: run held low from reset, then released
        clear_img();
        img[0] = enc(1, 9); img[1] = enc(2, 10); img[2] = enc(3, 11); img[3] = enc(14, 0); img[4] = enc(15, 0);
        img[9] = 16; img[10] = 20; img[11] = 24;
        start(0);
        for (int i = 0; i < 10; i++) cycle(1);
        check("t5_pc", pc, 0);
        check("t5_no_done", ndone, 0);
        check("t5_no_pulse", {out_valid, mem_we}, 0);
        run = 1; cyc = 1;
        run_prog(100, 0);
        check("t5_out", out_data, 12);
        check("t5_halted", halted, 1);

        // 6: reset in T5 of ADD
        clear_img();
        img[0] = enc(5, 3); img[1] = enc(2, 10); img[2] = enc(15, 0); img[10] = 4;
        start(1);
        while (tot < 9) cycle(1);
        rst = 0;
        cycle(0);
        check("t6_acc", acc, 0);
        check("t6_pc", pc, 0);
        check("t6_flags", {fc, fz}, 0);
        check("t6_pulses", {mem_we, done, halted}, 0);
        start(1);
        run_prog(100, 0);
        check("t6_acc_rerun", acc, 7);
        check("t6_halted", halted, 1);

        // Random programs, half of them with random run gating
        for (int p = 0; p < 24; p++) begin
            for (int i = 0; i < DEPTH; i++) img[i] = DW'($urandom_range(0, (1 << DW) - 1));
            start(1);
            lat_on = (p % 2 == 0);
            run_prog(400, p % 2 == 1);
            if (m_halt) check("rand_halted", halted, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
